// File: rtl/control_sequencer.sv
// control_sequencer: Moore fetch/decode/execute sequencer for the Mini SRC datapath.
// Optional feature macro: SINGLE_STEP_EN. It adds the Step input and a PAUSE state
// between instructions.
//
// Ports:
//   Clock, Reset_n         rising-edge clock; asynchronous active-low reset
//   Opcode                 decoded IR[31:27]
//   CON_FF                 branch condition result
//   Mem_ready              memory completes the current Read/Write
//   Step                   (SINGLE_STEP_EN only) leave PAUSE
//   *out, *in, Gr*         bus selects, load enables and register-field selects
//   Read, Write            memory strobes
//   ALU_op                 ALU operation; 0 whenever Zin is low
//   Run, Fault             running flag; sticky memory-timeout flag
module control_sequencer #(
  parameter logic [4:0]  ADD_OP      = 5'b00011,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [4:0] Opcode,
  input  logic       CON_FF,
  input  logic       Mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic       Step,
`endif
  output logic       PCout,
  output logic       Zlowout,
  output logic       Zhighout,
  output logic       MDRout,
  output logic       HIout,
  output logic       LOout,
  output logic       InPortout,
  output logic       Rout,
  output logic       BAout,
  output logic       Cout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       IRin,
  output logic       Yin,
  output logic       Zin,
  output logic       HIin,
  output logic       LOin,
  output logic       CONin,
  output logic       OutPortin,
  output logic       Rin,
  output logic       R15in,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Read,
  output logic       Write,
  output logic [4:0] ALU_op,
  output logic       Run,
  output logic       Fault
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);
  localparam bit TMO_EN = (MEM_TIMEOUT > 0);

  // T0..T7 are consecutive so that execute steps advance by +1.
  typedef enum logic [3:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
`ifdef SINGLE_STEP_EN
    S_PAUSE,
`endif
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_LD,
    C_LDI,
    C_ST,
    C_RT,
    C_IMM,
    C_MD,
    C_NN,
    C_BR,
    C_JR,
    C_JAL,
    C_IN,
    C_OUT,
    C_MFHI,
    C_MFLO,
    C_HALT,
    C_NOP
  } cls_e;

`ifdef SINGLE_STEP_EN
  localparam state_e END_ST = S_PAUSE;
`else
  localparam state_e END_ST = S_T0;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          fault_q, fault_d;
  cls_e          cls;
  state_e        last_st;
  logic          mem_step;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_RST;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    cls = C_NOP;
    unique case (1'b1)
      (Opcode == 5'd0):  cls = C_LD;
      (Opcode == 5'd1):  cls = C_LDI;
      (Opcode == 5'd2):  cls = C_ST;
      (Opcode >= 5'd3 && Opcode <= 5'd11):
        cls = C_RT;
      (Opcode >= 5'd12 && Opcode <= 5'd14):
        cls = C_IMM;
      (Opcode == 5'd15 || Opcode == 5'd16):
        cls = C_MD;
      (Opcode == 5'd17 || Opcode == 5'd18):
        cls = C_NN;
      (Opcode == 5'd19): cls = C_BR;
      (Opcode == 5'd20): cls = C_JR;
      (Opcode == 5'd21): cls = C_JAL;
      (Opcode == 5'd22): cls = C_IN;
      (Opcode == 5'd23): cls = C_OUT;
      (Opcode == 5'd24): cls = C_MFHI;
      (Opcode == 5'd25): cls = C_MFLO;
      (Opcode == 5'd27): cls = C_HALT;
      default:           cls = C_NOP;
    endcase
  end

  always_comb begin
    last_st = S_T3;
    unique case (cls)
      C_LD, C_ST:          last_st = S_T7;
      C_LDI, C_RT, C_IMM:  last_st = S_T5;
      C_MD, C_BR:          last_st = S_T6;
      C_NN, C_JAL:         last_st = S_T4;
      default:             last_st = S_T3;
    endcase
  end

  assign mem_step =
    (state_q == S_T1) ||
    (state_q == S_T6 && cls == C_LD) ||
    (state_q == S_T7 && cls == C_ST);

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    fault_d = fault_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_HALT: state_d = S_HALT;
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (Step) state_d = S_T0;
      end
`endif
      default: begin
        if (mem_step && !Mem_ready) begin
          wait_d = wait_q + 1'b1;
          if (TMO_EN && wait_d == TMO) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        end else if (state_q == S_T3 &&
                     cls == C_HALT) begin
          state_d = S_HALT;
        end else if (state_q == last_st) begin
          state_d = END_ST;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
    endcase
  end

  always_comb begin
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    MDRout    = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    InPortout = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    Cout      = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    CONin     = 1'b0;
    OutPortin = 1'b0;
    Rin       = 1'b0;
    R15in     = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    ALU_op    = 5'd0;
    case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        ALU_op = ADD_OP;
      end
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        // PC only updates on the cycle the fetch completes.
        PCin    = Mem_ready;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        unique case (cls)
          C_LD, C_LDI, C_ST: begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          end
          C_RT, C_IMM: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          C_MD: begin
            Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          C_NN: begin
            Grb = 1'b1; Rout = 1'b1;
            Zin = 1'b1; ALU_op = Opcode;
          end
          C_BR: begin
            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
          end
          C_JR: begin
            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          end
          C_JAL: begin
            PCout = 1'b1; R15in = 1'b1;
          end
          C_IN: begin
            InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_OUT: begin
            Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
          end
          C_MFHI: begin
            HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_MFLO: begin
            LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (cls)
          C_LD, C_LDI, C_ST: begin
            Cout = 1'b1; Zin = 1'b1; ALU_op = ADD_OP;
          end
          C_RT: begin
            Grc = 1'b1; Rout = 1'b1;
            Zin = 1'b1; ALU_op = Opcode;
          end
          C_IMM: begin
            Cout = 1'b1; Zin = 1'b1; ALU_op = Opcode;
          end
          C_MD: begin
            Grb = 1'b1; Rout = 1'b1;
            Zin = 1'b1; ALU_op = Opcode;
          end
          C_NN: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_BR: begin
            PCout = 1'b1; Yin = 1'b1;
          end
          C_JAL: begin
            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (cls)
          C_LD, C_ST: begin
            Zlowout = 1'b1; MARin = 1'b1;
          end
          C_LDI, C_RT, C_IMM: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_MD: begin
            Zlowout = 1'b1; LOin = 1'b1;
          end
          C_BR: begin
            Cout = 1'b1; Zin = 1'b1; ALU_op = ADD_OP;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (cls)
          C_LD: begin
            Read = 1'b1; MDRin = 1'b1;
          end
          C_ST: begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          end
          C_MD: begin
            Zhighout = 1'b1; HIin = 1'b1;
          end
          C_BR: begin
            Zlowout = 1'b1; PCin = CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (cls)
          C_LD: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign Run   = (state_q != S_RST) && (state_q != S_HALT);
  assign Fault = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized bench for control_sequencer.
// A per-instruction step model expands each opcode into its expected control words.
module tb_control_sequencer;

  localparam logic [4:0] ADD = 5'b00011;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  logic [4:0] Opcode = 5'd0;
  logic CON_FF = 1'b0;
  logic Mem_ready = 1'b1;
  logic PCout, Zlowout, Zhighout, MDRout, HIout;
  logic LOout, InPortout, Rout, BAout, Cout;
  logic PCin, IncPC, MARin, MDRin, IRin, Yin, Zin;
  logic HIin, LOin, CONin, OutPortin, Rin, R15in;
  logic Gra, Grb, Grc, Read, Write, Run, Fault;
  logic [4:0] ALU_op;

  always #5 Clock = ~Clock;

  control_sequencer #(
    .ADD_OP(ADD),
    .MEM_TIMEOUT(4)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Opcode(Opcode), .CON_FF(CON_FF),
    .Mem_ready(Mem_ready),
`ifdef SINGLE_STEP_EN
    .Step(1'b1),
`endif
    .PCout(PCout), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout),
    .InPortout(InPortout), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .PCin(PCin),
    .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin),
    .OutPortin(OutPortin), .Rin(Rin),
    .R15in(R15in), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Read(Read), .Write(Write),
    .ALU_op(ALU_op), .Run(Run), .Fault(Fault)
  );

  logic [34:0] obs;
  assign obs = {ALU_op, Fault, Run,
    PCout, Zlowout, Zhighout, MDRout, HIout,
    LOout, InPortout, Rout, BAout, Cout,
    PCin, IncPC, MARin, MDRin, IRin, Yin, Zin,
    HIin, LOin, CONin, OutPortin, Rin, R15in,
    Gra, Grb, Grc, Read, Write};

  localparam logic [34:0] K_WRITE  = 35'd1 << 0;
  localparam logic [34:0] K_READ   = 35'd1 << 1;
  localparam logic [34:0] K_GRC    = 35'd1 << 2;
  localparam logic [34:0] K_GRB    = 35'd1 << 3;
  localparam logic [34:0] K_GRA    = 35'd1 << 4;
  localparam logic [34:0] K_R15IN  = 35'd1 << 5;
  localparam logic [34:0] K_RIN    = 35'd1 << 6;
  localparam logic [34:0] K_OPIN   = 35'd1 << 7;
  localparam logic [34:0] K_CONIN  = 35'd1 << 8;
  localparam logic [34:0] K_LOIN   = 35'd1 << 9;
  localparam logic [34:0] K_HIIN   = 35'd1 << 10;
  localparam logic [34:0] K_ZIN    = 35'd1 << 11;
  localparam logic [34:0] K_YIN    = 35'd1 << 12;
  localparam logic [34:0] K_IRIN   = 35'd1 << 13;
  localparam logic [34:0] K_MDRIN  = 35'd1 << 14;
  localparam logic [34:0] K_MARIN  = 35'd1 << 15;
  localparam logic [34:0] K_INCPC  = 35'd1 << 16;
  localparam logic [34:0] K_PCIN   = 35'd1 << 17;
  localparam logic [34:0] K_COUT   = 35'd1 << 18;
  localparam logic [34:0] K_BAOUT  = 35'd1 << 19;
  localparam logic [34:0] K_ROUT   = 35'd1 << 20;
  localparam logic [34:0] K_IPOUT  = 35'd1 << 21;
  localparam logic [34:0] K_LOOUT  = 35'd1 << 22;
  localparam logic [34:0] K_HIOUT  = 35'd1 << 23;
  localparam logic [34:0] K_MDROUT = 35'd1 << 24;
  localparam logic [34:0] K_ZHOUT  = 35'd1 << 25;
  localparam logic [34:0] K_ZLOUT  = 35'd1 << 26;
  localparam logic [34:0] K_PCOUT  = 35'd1 << 27;
  localparam logic [34:0] K_RUN    = 35'd1 << 28;
  localparam logic [34:0] K_FAULT  = 35'd1 << 29;

  typedef struct {
    logic [4:0]  op;
    logic        cf;
    logic        mr;
    logic [34:0] exp;
  } stim_t;

  stim_t       sq[$];
  logic [34:0] oq[$];
  int total = 0;
  int bad = 0;

  function automatic logic [34:0] w(
    logic [34:0] c, logic [4:0] a);
    return c | K_RUN | {a, 30'd0};
  endfunction

  function automatic logic [34:0] t0w();
    return w(K_PCOUT | K_MARIN | K_INCPC | K_ZIN, ADD);
  endfunction

  task automatic push(input logic [4:0] op,
    input logic cf, input logic mr,
    input logic [34:0] e);
    stim_t s;
    s.op = op; s.cf = cf; s.mr = mr; s.exp = e;
    sq.push_back(s);
  endtask

  // One instruction: w1 fetch waits, wm execute-memory waits.
  task automatic build(input logic [4:0] op,
    input int w1, input int wm, input logic cf);
    logic r;
    r = 1'($urandom_range(0, 1));
    push(op, cf, r, t0w());
    for (int i = 0; i < w1; i++)
      push(op, cf, 1'b0, w(K_ZLOUT | K_READ | K_MDRIN, 0));
    push(op, cf, 1'b1,
      w(K_ZLOUT | K_READ | K_MDRIN | K_PCIN, 0));
    push(op, cf, r, w(K_MDROUT | K_IRIN, 0));
    if (op <= 5'd2) begin
      push(op, cf, r, w(K_GRB | K_BAOUT | K_YIN, 0));
      push(op, cf, r, w(K_COUT | K_ZIN, ADD));
      if (op == 5'd1) begin
        push(op, cf, r, w(K_ZLOUT | K_GRA | K_RIN, 0));
      end else begin
        push(op, cf, r, w(K_ZLOUT | K_MARIN, 0));
        if (op == 5'd0) begin
          for (int i = 0; i < wm; i++)
            push(op, cf, 1'b0, w(K_READ | K_MDRIN, 0));
          push(op, cf, 1'b1, w(K_READ | K_MDRIN, 0));
          push(op, cf, r, w(K_MDROUT | K_GRA | K_RIN, 0));
        end else begin
          push(op, cf, r, w(K_GRA | K_ROUT | K_MDRIN, 0));
          for (int i = 0; i < wm; i++)
            push(op, cf, 1'b0, w(K_WRITE, 0));
          push(op, cf, 1'b1, w(K_WRITE, 0));
        end
      end
    end else if (op <= 5'd14) begin
      push(op, cf, r, w(K_GRB | K_ROUT | K_YIN, 0));
      if (op <= 5'd11)
        push(op, cf, r, w(K_GRC | K_ROUT | K_ZIN, op));
      else
        push(op, cf, r, w(K_COUT | K_ZIN, op));
      push(op, cf, r, w(K_ZLOUT | K_GRA | K_RIN, 0));
    end else if (op <= 5'd16) begin
      push(op, cf, r, w(K_GRA | K_ROUT | K_YIN, 0));
      push(op, cf, r, w(K_GRB | K_ROUT | K_ZIN, op));
      push(op, cf, r, w(K_ZLOUT | K_LOIN, 0));
      push(op, cf, r, w(K_ZHOUT | K_HIIN, 0));
    end else if (op <= 5'd18) begin
      push(op, cf, r, w(K_GRB | K_ROUT | K_ZIN, op));
      push(op, cf, r, w(K_ZLOUT | K_GRA | K_RIN, 0));
    end else if (op == 5'd19) begin
      push(op, cf, r, w(K_GRA | K_ROUT | K_CONIN, 0));
      push(op, cf, r, w(K_PCOUT | K_YIN, 0));
      push(op, cf, r, w(K_COUT | K_ZIN, ADD));
      push(op, cf, r,
        w(K_ZLOUT | (cf ? K_PCIN : 35'd0), 0));
    end else if (op == 5'd20) begin
      push(op, cf, r, w(K_GRA | K_ROUT | K_PCIN, 0));
    end else if (op == 5'd21) begin
      push(op, cf, r, w(K_PCOUT | K_R15IN, 0));
      push(op, cf, r, w(K_GRA | K_ROUT | K_PCIN, 0));
    end else if (op == 5'd22) begin
      push(op, cf, r, w(K_IPOUT | K_GRA | K_RIN, 0));
    end else if (op == 5'd23) begin
      push(op, cf, r, w(K_GRA | K_ROUT | K_OPIN, 0));
    end else if (op == 5'd24) begin
      push(op, cf, r, w(K_HIOUT | K_GRA | K_RIN, 0));
    end else if (op == 5'd25) begin
      push(op, cf, r, w(K_LOOUT | K_GRA | K_RIN, 0));
    end else begin
      push(op, cf, r, w(35'd0, 0));
    end
  endtask

  task automatic play();
    oq.delete();
    foreach (sq[i]) begin
      Opcode = sq[i].op;
      CON_FF = sq[i].cf;
      Mem_ready = sq[i].mr;
      @(negedge Clock);
      oq.push_back(obs);
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Mem_ready = 1'b0;
    #2;
    total++;
    if (obs !== 35'd0) begin
      bad++;
      $display("FAIL reset_outs got=%h want=0", obs);
    end
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    @(negedge Clock);
    total++;
    if (obs !== 35'd0) begin
      bad++;
      $display("FAIL rst_state got=%h want=0", obs);
    end
    @(posedge Clock);
    #1;
    @(negedge Clock);
    total++;
    if (obs !== t0w()) begin
      bad++;
      $display("FAIL first_t0 got=%h want=%h",
        obs, t0w());
    end
  endtask

  task automatic test_add();
    do_reset();
    sq.delete();
    build(5'd3, 0, 0, 1'b0);
    push(5'd26, 1'b0, 1'b1, t0w());
    play();
    for (int i = 0; i < sq.size(); i++) begin
      total++;
      if (oq[i] !== sq[i].exp) begin
        bad++;
        $display("FAIL add step%0d got=%h want=%h",
          i, oq[i], sq[i].exp);
      end
    end
  endtask

  task automatic test_ld_waits();
    do_reset();
    sq.delete();
    build(5'd0, 2, 3, 1'b0);
    push(5'd26, 1'b0, 1'b1, t0w());
    play();
    for (int i = 0; i < sq.size(); i++) begin
      total++;
      if (oq[i] !== sq[i].exp) begin
        bad++;
        $display("FAIL ld step%0d got=%h want=%h",
          i, oq[i], sq[i].exp);
      end
    end
  endtask

  task automatic test_br();
    do_reset();
    sq.delete();
    build(5'd19, 0, 0, 1'b0);
    build(5'd19, 1, 0, 1'b1);
    push(5'd26, 1'b0, 1'b1, t0w());
    play();
    for (int i = 0; i < sq.size(); i++) begin
      total++;
      if (oq[i] !== sq[i].exp) begin
        bad++;
        $display("FAIL br step%0d got=%h want=%h",
          i, oq[i], sq[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    do_reset();
    sq.delete();
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      build(op, int'($urandom_range(0, 3)),
        int'($urandom_range(0, 3)),
        1'($urandom_range(0, 1)));
    end
    push(5'd26, 1'b0, 1'b1, t0w());
    play();
    for (int i = 0; i < sq.size(); i++) begin
      total++;
      if (oq[i] !== sq[i].exp) begin
        bad++;
        $display("FAIL b2b step%0d op=%0d got=%h want=%h",
          i, sq[i].op, oq[i], sq[i].exp);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    sq.delete();
    build(5'd27, 1, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      push(5'd27, 1'b0, 1'($urandom_range(0, 1)), 35'd0);
    play();
    for (int i = 0; i < sq.size(); i++) begin
      total++;
      if (oq[i] !== sq[i].exp) begin
        bad++;
        $display("FAIL halt step%0d got=%h want=%h",
          i, oq[i], sq[i].exp);
      end
    end
    do_reset();
    @(negedge Clock);
    total++;
    if (obs !== t0w()) begin
      bad++;
      $display("FAIL halt_rst_t0 got=%h want=%h",
        obs, t0w());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    sq.delete();
    build(5'd2, 0, 3, 1'b0);
    void'(sq.pop_back());
    void'(sq.pop_back());
    play();
    Mem_ready = 1'b0;
    #1;
    total++;
    if (obs !== w(K_WRITE, 0)) begin
      bad++;
      $display("FAIL st_t7 got=%h want=%h",
        obs, w(K_WRITE, 0));
    end
    Reset_n = 1'b0;
    #1;
    total++;
    if (obs !== 35'd0) begin
      bad++;
      $display("FAIL async_rst got=%h want=0", obs);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_timeout();
    do_reset();
    sq.delete();
    push(5'd3, 1'b0, 1'b0, t0w());
    for (int i = 0; i < 4; i++)
      push(5'd3, 1'b0, 1'b0,
        w(K_ZLOUT | K_READ | K_MDRIN, 0));
    for (int i = 0; i < 6; i++)
      push(5'd3, 1'b0, 1'($urandom_range(0, 1)),
        K_FAULT);
    play();
    for (int i = 0; i < sq.size(); i++) begin
      total++;
      if (oq[i] !== sq[i].exp) begin
        bad++;
        $display("FAIL tmo step%0d got=%h want=%h",
          i, oq[i], sq[i].exp);
      end
    end
    Mem_ready = 1'b1;
    do_reset();
    @(negedge Clock);
    total++;
    if (obs !== t0w()) begin
      bad++;
      $display("FAIL fault_clr got=%h want=%h",
        obs, t0w());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_waits();
    test_br();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Moore-style fetch/decode/execute sequencer for the Mini SRC datapath.
- Fetches each instruction into the Instruction Register (drives IRin).
- Consumes the 5-bit Opcode the IR decodes, and steps through per-class execute sequences driving datapath, memory and I/O controls.
- Handles memory wait states, a branch-condition input, halt, and an optional memory-timeout fault.

Parameters:
- ADD_OP, 5'b00011, ALU_op value used for address/offset addition (ld, ldi, st, br).
- MEM_TIMEOUT, 0, max consecutive wait cycles in a memory step; 0 disables the timeout.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Opcode  in  5  decoded IR[31:27]; stable from T3 until return to T0.
- CON_FF  in  1  branch condition result, valid the cycle after CONin.
- Mem_ready  in  1  memory completes the current Read/Write this cycle.
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout  out  1 each  bus source selects.
- Rout, BAout, Cout  out  1 each  register-file, base-address and constant bus selects.
- PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin, Rin, R15in  out  1 each  load enables.
- Gra, Grb, Grc  out  1 each  register-field selects.
- Read, Write  out  1 each  memory strobes.
- ALU_op  out  5  ALU operation; 0 when Zin is low.
- Run  out  1  processor running.
- Fault  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (Reset_n low, any time, including mid-instruction):
  - State becomes RST; wait counter clears.
  - All outputs go to 0; Run=0, Fault=0.
  - The first rising edge after release moves RST to T0.
- Outputs are pure decodes of the current state (plus Opcode and CON_FF where stated). Unlisted outputs are 0 in every step.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin (ALU_op=ADD_OP).
  - T1: Zlowout, PCin, Read, MDRin. Hold while Mem_ready=0; PCin is asserted only on the cycle Mem_ready=1.
  - T2: MDRout, IRin.
- Execute steps T3..T7, by Opcode; after the last step go to T0:
  - ld 00000: T3 Grb, BAout, Yin. T4 Cout, Zin, ALU_op=ADD_OP. T5 Zlowout, MARin. T6 Read, MDRin (wait on Mem_ready). T7 MDRout, Gra, Rin.
  - ldi 00001: T3 and T4 as ld. T5 Zlowout, Gra, Rin.
  - st 00010: T3–T5 as ld. T6 Gra, Rout, MDRin. T7 Write (wait on Mem_ready).
  - R-type 00011–01011: T3 Grb, Rout, Yin. T4 Grc, Rout, Zin, ALU_op=Opcode. T5 Zlowout, Gra, Rin.
  - addi/andi/ori 01100–01110: T3 Grb, Rout, Yin. T4 Cout, Zin, ALU_op=Opcode. T5 Zlowout, Gra, Rin.
  - mul/div 01111–10000: T3 Gra, Rout, Yin. T4 Grb, Rout, Zin, ALU_op=Opcode. T5 Zlowout, LOin. T6 Zhighout, HIin.
  - neg/not 10001–10010: T3 Grb, Rout, Zin, ALU_op=Opcode. T4 Zlowout, Gra, Rin.
  - br 10011: T3 Gra, Rout, CONin. T4 PCout, Yin. T5 Cout, Zin, ALU_op=ADD_OP. T6 Zlowout, and PCin only if CON_FF=1.
  - jr 10100: T3 Gra, Rout, PCin.
  - jal 10101: T3 PCout, R15in. T4 Gra, Rout, PCin.
  - in 10110: T3 InPortout, Gra, Rin.
  - out 10111: T3 Gra, Rout, OutPortin.
  - mfhi 11000: T3 HIout, Gra, Rin.
  - mflo 11001: T3 LOout, Gra, Rin.
  - nop 11010: T3 no controls.
  - halt 11011: T3 goes to HALT.
  - 11100–11111: treated as nop.
- HALT: all controls 0, Run=0; held until reset.
- Run=1 in every state except RST and HALT.
- Wait counter:
  - Counts cycles with Mem_ready=0 in T1, ld-T6 and st-T7; clears on leaving those steps.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT: next state is HALT, Fault=1 (sticky until reset), Read/Write drop.
- Mem_ready is ignored outside memory steps.
- Single-cycle memory (Mem_ready tied 1) gives zero wait cycles.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds input Step (1 bit).
  - After the final execute step the sequencer enters PAUSE (controls 0, Run=1) instead of T0.
  - PAUSE goes to T0 on the first cycle Step=1.
  - halt and timeout still go to HALT.
  - Reset clears PAUSE.
- Undefined: no Step port and no PAUSE state; instructions run back-to-back.

Test Plan:
- add (Opcode 00011), Mem_ready=1 → T0..T5 in 6 cycles; ALU_op=00011 with Zin at T4; Gra+Rin at T5; back at T0 on cycle 7.
- ld (00000), Mem_ready low 2 cycles in T1 and 3 cycles in T6 → T1 lasts 3 cycles with PCin on the last only; T6 lasts 4 cycles; total 13 cycles.
- br (10011): CON_FF=0 → no PCin at T6. CON_FF=1 → PCin with Zlowout at T6.
- halt (11011) → Run falls after T3; all controls 0 for 20 cycles; Reset_n pulse → RST then T0, Run=1.
- Reset_n low during st T7 with Write=1 → Write and all outputs 0 immediately (asynchronous), before the next edge.
- MEM_TIMEOUT=4, Mem_ready=0 in T1 → HALT after 4 wait cycles; Fault=1, Read=0.
